// File: rtl/alu_flag_wb.sv
// ALU writeback stage: condition check against the NZCV flag register, a 2-entry result FIFO, and an optional squash counter.
// Optional feature macro: ALU_WB_STATS_EN (enables the saturating cond_fail_cnt counter).
module alu_flag_wb #(
  parameter int WIDTH = 4,
  parameter int RD_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_n,
  input  logic             in_z,
  input  logic             in_c,
  input  logic             in_v,
  input  logic             in_set_flags,
  input  logic [3:0]       in_cond,
  input  logic [RD_W-1:0]  in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [RD_W-1:0]  out_rd,
  output logic [3:0]       flags,
  output logic [7:0]       cond_fail_cnt
);

  localparam int DEPTH = 2;

  logic [WIDTH-1:0] data_mem_reg [DEPTH];
  logic [RD_W-1:0]  rd_mem_reg   [DEPTH];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic             ready_en_reg;
  logic [3:0]       flags_reg;
  logic [DEPTH-1:0] wr_en;
  logic             fn, fz, fc, fv;
  logic             cond_pass;
  logic             accept;
  logic             push;
  logic             pop;

  assign {fn, fz, fc, fv} = flags_reg;

  always_comb begin
    cond_pass = 1'b0;
    case (in_cond)
      4'd0:    cond_pass = fz;
      4'd1:    cond_pass = !fz;
      4'd2:    cond_pass = fc;
      4'd3:    cond_pass = !fc;
      4'd4:    cond_pass = fn;
      4'd5:    cond_pass = !fn;
      4'd6:    cond_pass = fv;
      4'd7:    cond_pass = !fv;
      4'd8:    cond_pass = fc && !fz;
      4'd9:    cond_pass = !fc || fz;
      4'd10:   cond_pass = (fn == fv);
      4'd11:   cond_pass = (fn != fv);
      4'd12:   cond_pass = !fz && (fn == fv);
      4'd13:   cond_pass = fz || (fn != fv);
      4'd14:   cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // in_ready stays low until the first clock edge after reset release.
  assign in_ready  = ready_en_reg && (count_reg < 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && cond_pass;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_reg == 1'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_reg[i] <= '0;
        rd_mem_reg[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          data_mem_reg[i] <= in_result;
          rd_mem_reg[i]   <= in_rd;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
      ready_en_reg <= 1'b0;
      flags_reg    <= 4'b0000;
    end else begin
      ready_en_reg <= 1'b1;
      count_reg    <= count_next;
      if (push) begin
        wr_ptr_reg <= !wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= !rd_ptr_reg;
      end
      if (push && in_set_flags) begin
        flags_reg <= {in_n, in_z, in_c, in_v};
      end
    end
  end

  assign out_data = out_valid ? data_mem_reg[rd_ptr_reg] : '0;
  assign out_rd   = out_valid ? rd_mem_reg[rd_ptr_reg] : '0;
  assign flags    = flags_reg;

`ifdef ALU_WB_STATS_EN
  logic [7:0] fail_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt_reg <= 8'd0;
    end else if (accept && !cond_pass && (fail_cnt_reg != 8'hFF)) begin
      fail_cnt_reg <= fail_cnt_reg + 8'd1;
    end
  end

  assign cond_fail_cnt = fail_cnt_reg;
`else
  assign cond_fail_cnt = 8'd0;
`endif

endmodule
